// File: rtl/writeback_unit.sv
// Write-back stage feeding the register file: merges single-cycle ALU results with
// buffered load results, keeps program order, and tracks pending load targets.
module writeback_unit #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        aluValid,
    input  logic [4:0]  aluReg,
    input  logic [31:0] aluData,
    output logic        aluStall,
    input  logic        memValid,
    input  logic [4:0]  memReg,
    input  logic [31:0] memData,
    output logic        memReady,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        regWrite,
    output logic [31:0] pendingMask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifoReg  [DEPTH];
    logic [31:0]      fifoData [DEPTH];
    logic [DEPTH-1:0] fifoKill;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starveCnt;

    logic             fifoEmpty;
    logic             aluWin;
    logic             popHead;
    logic             memAccept;
    logic             pushLoad;
    logic [PW-1:0]    nextRd;
    logic [CW-1:0]    nextCount;
    logic [DEPTH-1:0] liveNow;
    logic [DEPTH-1:0] liveNext;
    logic [DEPTH-1:0] killHit;
    logic [DEPTH-1:0] nextKill;
    logic [31:0]      nextMask;
    logic [4:0]       tgtReg;

    // A load racing an ALU write to the same register is older, so it is dropped.
    always_comb begin
        fifoEmpty = (count == '0);
        aluStall  = (starveCnt == SW'(STARVE_LIMIT)) && !fifoEmpty;
        aluWin    = aluValid && !aluStall;
        popHead   = !aluWin && !fifoEmpty;
        memReady  = (count < CW'(DEPTH));
        memAccept = memValid && memReady;
        pushLoad  = memAccept && (memReg != 5'd0) && !(aluWin && (aluReg == memReg));
        nextRd    = popHead ? rdPtr + PW'(1) : rdPtr;
        nextCount = count;
        if (pushLoad && !popHead)
            nextCount = count + CW'(1);
        else if (!pushLoad && popHead)
            nextCount = count - CW'(1);
    end

    // Pending mask is computed from the post-edge queue contents so it moves with push/pop/kill.
    always_comb begin
        liveNow  = '0;
        liveNext = '0;
        killHit  = '0;
        nextKill = fifoKill;
        nextMask = '0;
        tgtReg   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            liveNow[i]  = CW'(PW'(PW'(i) - rdPtr)) < count;
            liveNext[i] = CW'(PW'(PW'(i) - nextRd)) < nextCount;
            killHit[i]  = aluWin && (aluReg != 5'd0) && liveNow[i] && (fifoReg[i] == aluReg);
            if (pushLoad && (wrPtr == PW'(i))) begin
                nextKill[i] = 1'b0;
                tgtReg      = memReg;
            end else begin
                nextKill[i] = fifoKill[i] | killHit[i];
                tgtReg      = fifoReg[i];
            end
            if (liveNext[i] && !nextKill[i])
                nextMask[tgtReg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pushLoad) begin
            fifoReg[wrPtr]  <= memReg;
            fifoData[wrPtr] <= memData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdPtr         <= '0;
            wrPtr         <= '0;
            count         <= '0;
            fifoKill      <= '0;
            starveCnt     <= '0;
            pendingMask   <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else begin
            rdPtr       <= nextRd;
            count       <= nextCount;
            fifoKill    <= nextKill;
            pendingMask <= nextMask;
            if (pushLoad)
                wrPtr <= wrPtr + PW'(1);

            if (popHead || fifoEmpty)
                starveCnt <= '0;
            else if (aluWin)
                starveCnt <= starveCnt + SW'(1);

            // A killed head still uses the port slot, just without a write.
            if (aluWin) begin
                regWrite      <= (aluReg != 5'd0);
                writeRegister <= aluReg;
                writeData     <= aluData;
            end else if (popHead) begin
                regWrite      <= !fifoKill[rdPtr];
                writeRegister <= fifoReg[rdPtr];
                writeData     <= fifoData[rdPtr];
            end else begin
                regWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed, table-driven bench for writeback_unit with hand-written reset sequence.
module tb_writeback_unit;

    typedef struct {
        logic        aluValid;
        logic [4:0]  aluReg;
        logic [31:0] aluData;
        logic        memValid;
        logic [4:0]  memReg;
        logic [31:0] memData;
        logic        expWrite;
        logic [4:0]  expReg;
        logic [31:0] expData;
        logic [31:0] expMask;
        logic        expReady;
        logic        expStall;
    } vecT;

    logic        clk;
    logic        resetN;
    logic        aluValid;
    logic [4:0]  aluReg;
    logic [31:0] aluData;
    logic        aluStall;
    logic        memValid;
    logic [4:0]  memReg;
    logic [31:0] memData;
    logic        memReady;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [31:0] pendingMask;

    int checks = 0;
    int errors = 0;
    vecT vecQ[$];

    writeback_unit #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk),
        .resetN(resetN),
        .aluValid(aluValid),
        .aluReg(aluReg),
        .aluData(aluData),
        .aluStall(aluStall),
        .memValid(memValid),
        .memReg(memReg),
        .memData(memData),
        .memReady(memReady),
        .writeRegister(writeRegister),
        .writeData(writeData),
        .regWrite(regWrite),
        .pendingMask(pendingMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vecT makeVec(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                    input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                    input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                    input logic [31:0] em, input logic erdy, input logic est);
        vecT v;
        v.aluValid = av;  v.aluReg = ar;  v.aluData = ad;
        v.memValid = mv;  v.memReg = mr;  v.memData = md;
        v.expWrite = ew;  v.expReg = er;  v.expData = ed;
        v.expMask  = em;  v.expReady = erdy;  v.expStall = est;
        return v;
    endfunction

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mr, input logic [31:0] md);
        aluValid = av;
        aluReg   = ar;
        aluData  = ad;
        memValid = mv;
        memReg   = mr;
        memData  = md;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    initial begin
        // Vectors start from the reset state; expected values describe the state after each edge.
        vecQ.push_back(makeVec(1, 5,  32'hDEADBEEF, 0, 0, 32'h0,   1, 5,  32'hDEADBEEF, 32'h0,  1, 0));
        vecQ.push_back(makeVec(1, 0,  32'h12345678, 0, 0, 32'h0,   0, 0,  32'h0,        32'h0,  1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   0, 0,  32'h0,        32'h0,  1, 0));
        vecQ.push_back(makeVec(1, 20, 32'hA0,       1, 1, 32'h101, 1, 20, 32'hA0,       32'h2,  1, 0));
        vecQ.push_back(makeVec(1, 21, 32'hA1,       1, 2, 32'h102, 1, 21, 32'hA1,       32'h6,  1, 0));
        vecQ.push_back(makeVec(1, 22, 32'hA2,       1, 3, 32'h103, 1, 22, 32'hA2,       32'hE,  1, 0));
        vecQ.push_back(makeVec(1, 23, 32'hA3,       1, 4, 32'h104, 1, 23, 32'hA3,       32'h1E, 0, 1));
        vecQ.push_back(makeVec(1, 24, 32'hA4,       1, 6, 32'h106, 1, 1,  32'h101,      32'h1C, 1, 0));
        vecQ.push_back(makeVec(1, 25, 32'hA5,       1, 6, 32'h106, 1, 25, 32'hA5,       32'h5C, 0, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   1, 2,  32'h102,      32'h58, 1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   1, 3,  32'h103,      32'h50, 1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   1, 4,  32'h104,      32'h40, 1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   1, 6,  32'h106,      32'h0,  1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        1, 7, 32'h11,  0, 0,  32'h0,        32'h80, 1, 0));
        vecQ.push_back(makeVec(1, 7,  32'h22,       0, 0, 32'h0,   1, 7,  32'h22,       32'h0,  1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   0, 0,  32'h0,        32'h0,  1, 0));
        vecQ.push_back(makeVec(1, 9,  32'h33,       1, 9, 32'h99,  1, 9,  32'h33,       32'h0,  1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   0, 0,  32'h0,        32'h0,  1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        1, 0, 32'h55,  0, 0,  32'h0,        32'h0,  1, 0));
        vecQ.push_back(makeVec(0, 0,  32'h0,        0, 0, 32'h0,   0, 0,  32'h0,        32'h0,  1, 0));

        resetN   = 1'b0;
        aluValid = 1'b0;
        aluReg   = '0;
        aluData  = '0;
        memValid = 1'b0;
        memReg   = '0;
        memData  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset regWrite", 32'(regWrite), 32'd0);
        checkOutput("reset writeRegister", 32'(writeRegister), 32'd0);
        checkOutput("reset writeData", writeData, 32'd0);
        checkOutput("reset pendingMask", pendingMask, 32'd0);
        checkOutput("reset memReady", 32'(memReady), 32'd1);
        checkOutput("reset aluStall", 32'(aluStall), 32'd0);
        resetN = 1'b1;

        for (int i = 0; i < vecQ.size(); i++) begin
            applyStimulus(vecQ[i].aluValid, vecQ[i].aluReg, vecQ[i].aluData,
                          vecQ[i].memValid, vecQ[i].memReg, vecQ[i].memData);
            checkOutput($sformatf("v%0d regWrite", i), 32'(regWrite), 32'(vecQ[i].expWrite));
            if (vecQ[i].expWrite) begin
                checkOutput($sformatf("v%0d writeRegister", i), 32'(writeRegister), 32'(vecQ[i].expReg));
                checkOutput($sformatf("v%0d writeData", i), writeData, vecQ[i].expData);
            end
            checkOutput($sformatf("v%0d pendingMask", i), pendingMask, vecQ[i].expMask);
            checkOutput($sformatf("v%0d memReady", i), 32'(memReady), 32'(vecQ[i].expReady));
            checkOutput($sformatf("v%0d aluStall", i), 32'(aluStall), 32'(vecQ[i].expStall));
        end

        // Queue three loads behind ALU traffic, then reset asynchronously mid-queue.
        applyStimulus(1, 30, 32'hC0, 1, 10, 32'h210);
        applyStimulus(1, 30, 32'hC1, 1, 11, 32'h211);
        applyStimulus(1, 30, 32'hC2, 1, 12, 32'h212);
        checkOutput("queued pendingMask", pendingMask, 32'h0000_1C00);
        checkOutput("queued regWrite", 32'(regWrite), 32'd1);
        checkOutput("queued writeData", writeData, 32'hC2);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async reset regWrite", 32'(regWrite), 32'd0);
        checkOutput("async reset pendingMask", pendingMask, 32'd0);
        checkOutput("async reset memReady", 32'(memReady), 32'd1);
        checkOutput("async reset aluStall", 32'(aluStall), 32'd0);
        aluValid = 1'b0;
        memValid = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
            checkOutput($sformatf("post reset %0d regWrite", i), 32'(regWrite), 32'd0);
            checkOutput($sformatf("post reset %0d pendingMask", i), pendingMask, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
